sort_loader: RTL
================

Name: sort_loader

Overview:
- Upstream feeder for the descending combinational sorter.
- Accepts a serial stream of WIDTH-bit values over a valid/ready handshake and assembles them into one packed frame of NUM_VALS slots.
- Holds the frame and presents it on a valid/ready output whose data bus connects directly to the sorter's packed input.
- Short frames, terminated by in_last, are zero-padded. Zeros sink to the bottom of a descending sort.

Parameters:
- NUM_VALS, 8, number of slots per frame (>=2).
- WIDTH, 4, bits per value.
- CNT_W (localparam), $clog2(NUM_VALS+1), width of the fill count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  value for the beat.
- in_last  input  1  beat is the final value of the frame; qualified by in_valid.
- out_valid  output  1  frame is held and presented.
- out_ready  input  1  downstream consumes the frame.
- out_data  output  NUM_VALS*WIDTH  packed frame. Slot i occupies bits [(NUM_VALS-i)*WIDTH-1 -: WIDTH]; slot 0 (the first accepted value) is at the MSB end.
- out_count  output  CNT_W  number of real (non-pad) values in the frame, 1..NUM_VALS.

Behaviour:
- One clock; rst_n is asynchronous and active-low.
- While rst_n=0:
  - state=FILL, fill pointer=0.
  - Frame register all zeros, out_valid=0, out_count=0.
  - in_ready=1 (decoded from state); upstream must not drive in_valid during reset.
- States:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Beat accept: in_valid & in_ready on a rising edge.
  - in_data is written to slot[ptr].
  - ptr increments; out_count follows ptr.
- FILL->HOLD on an accepted beat when ptr==NUM_VALS-1 or in_last=1. Whichever occurs first ends the frame.
  - in_last together with the NUM_VALS-th beat is a normal full frame.
- Slots not written in the current frame read 0.
- out_valid rises on the cycle after the terminating beat (1-cycle latency).
- HOLD:
  - out_data and out_count stay stable until out_valid & out_ready.
  - in_valid is ignored (no accept).
- HOLD->FILL on out_valid & out_ready. On the same edge, the frame register is cleared to 0 and ptr/out_count are cleared to 0.
  - in_ready returns to 1 the cycle after handoff.
  - Maximum throughput is one frame per NUM_VALS+1 cycles with out_ready held high.
- in_valid may drop between beats (gaps); gaps have no effect on slot order.
- An in_last with no beat accepted has no effect (in_last is only sampled on accept).
- Asserting rst_n mid-fill or mid-hold discards the partial or held frame immediately.
- Reserved behaviour for the verifier: a full frame with no in_last and ptr==NUM_VALS-1 must not wrap ptr to 0 while in FILL. The transition to HOLD precludes this.

Test Plan (NUM_VALS=8, WIDTH=4):
- Reset then 8 beats 3,1,4,1,5,9,2,6 on consecutive cycles, in_last on the 8th -> one cycle later out_valid=1, out_data=32'h31415926, out_count=8, in_ready=0.
- Short frame 7,2,5 with in_last on 5 -> out_data=32'h72500000, out_count=3. After handoff, the next frame 1..8 yields 32'h12345678 with no residue.
- Single beat A with in_last -> out_data=32'hA0000000, out_count=1.
- Backpressure: frame held with out_ready=0 for 5 cycles while in_valid=1, in_data=F -> out_data unchanged, in_ready=0, no beat accepted. Raise out_ready -> out_valid drops next cycle, in_ready=1.
- in_valid toggling 1,0,1,0 across the 8 beats of frame 3,1,4,1,5,9,2,6 -> identical result 32'h31415926.
- rst_n pulsed low after 4 beats -> out_count=0, out_data=0 asynchronously. The subsequent beats 8,8,last 8 -> 32'h88800000, out_count=3.

Source files
------------

// File: rtl/sort_loader.sv
// sort_loader: serial-to-parallel frame assembler feeding the descending sorter.
//
// Collects WIDTH-bit values over a valid/ready input stream into a packed frame
// of NUM_VALS slots. A frame ends on the NUM_VALS-th beat or on in_last. The
// frame is then held on a valid/ready output until it is consumed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   block can accept a beat (high while filling)
//   in_data    beat value
//   in_last    final beat of the frame (qualified by in_valid)
//   out_valid  frame held and presented
//   out_ready  downstream consumes the frame
//   out_data   packed frame, slot 0 at the MSB end
//   out_count  number of real values in the frame
module sort_loader #(
   parameter int unsigned NUM_VALS = 8,
   parameter int unsigned WIDTH    = 4,
   localparam int unsigned CNT_W   = $clog2(NUM_VALS + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_VALS*WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]          out_count
);

   typedef enum logic {StFill, StHold} state_e;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            ptr_q, ptr_d;
   logic [NUM_VALS*WIDTH-1:0]   frame_q, frame_d;

   logic accept;
   logic handoff;

   assign in_ready  = (state_q == StFill);
   assign out_valid = (state_q == StHold);
   assign out_data  = frame_q;
   assign out_count = ptr_q;

   assign accept  = in_valid & in_ready;
   assign handoff = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      frame_d = frame_q;
      unique case (state_q)
         StFill: begin
            if (accept) begin
               for (int unsigned i = 0; i < NUM_VALS; i++) begin
                  if (ptr_q == CNT_W'(i)) begin
                     frame_d[(NUM_VALS-i)*WIDTH-1 -: WIDTH] = in_data;
                  end
               end
               ptr_d = ptr_q + 1'b1;
               // Last slot filled or explicit end: ptr never wraps inside FILL.
               if (in_last || (ptr_q == CNT_W'(NUM_VALS - 1))) begin
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (handoff) begin
               // Clearing here guarantees unwritten slots of the next frame read 0.
               state_d = StFill;
               ptr_d   = '0;
               frame_d = '0;
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFill;
         ptr_q   <= '0;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         frame_q <= frame_d;
      end
   end

endmodule
